fft_calc_ctrl: RTL and testbench

FFT_CALC_CTRL -- requirements
Module: fft_calc_ctrl

---
 rtl/fft_calc_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fft_calc_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_calc_ctrl.sv
// fft_calc_ctrl: sequencer for an in-place radix-2 FFT, driving RAM strobes/addresses and twiddle index.
// Define FFT_CALC_CTRL_BITREV_EN to add a bit-reversal reorder pass ahead of stage 0.
module fft_calc_ctrl #(
    parameter int unsigned BFLY_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_DATA_LOADED,
    input  logic [11:0] i_SAMPLES_NUMBER,
    output logic        o_CALC_END,
    output logic        o_BUSY,
    output logic        o_RD_ram,
    output logic [11:0] o_RD_INDEX_ram,
    output logic        o_WR_ram,
    output logic [11:0] o_WR_INDEX_ram,
    output logic [10:0] o_TWIDDLE_INDEX,
    output logic [3:0]  o_STAGE,
    output logic        o_SWAP
);
    localparam int unsigned AW = 12;
    localparam int unsigned KW = 11;
    localparam int unsigned SW = 4;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_RD_A = 4'd1;
    localparam logic [3:0] S_RD_B = 4'd2;
    localparam logic [3:0] S_WAIT = 4'd3;
    localparam logic [3:0] S_WR_A = 4'd4;
    localparam logic [3:0] S_WR_B = 4'd5;
    localparam logic [3:0] S_DONE = 4'd6;
`ifdef FFT_CALC_CTRL_BITREV_EN
    localparam logic [3:0] S_BR_A = 4'd7;
    localparam logic [3:0] S_BR_B = 4'd8;
    localparam logic [3:0] S_BW_A = 4'd9;
    localparam logic [3:0] S_BW_B = 4'd10;
`endif

    logic [3:0]    state, state_nxt;
    logic [AW-1:0] n_q, n_nxt;
    logic [SW-1:0] l_q, l_nxt, s_q, s_nxt, w_q, w_nxt;
    logic [KW-1:0] k_q, k_nxt;
    logic          n_ok;
    logic [SW-1:0] l_in;
    logic [AW-1:0] half_c, pos_c, top_c, bot_c;
    logic [KW-1:0] tw_c;
    logic          busy_nxt, end_nxt, rd_nxt, wr_nxt, swap_nxt;
    logic [AW-1:0] rd_idx_nxt, wr_idx_nxt;
    logic [KW-1:0] tw_nxt;
    logic [SW-1:0] stage_nxt;
`ifdef FFT_CALC_CTRL_BITREV_EN
    logic [AW-1:0] i_q, i_nxt, rev_c;
    logic [AW:0]   swap_res;

    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] x, input logic [SW-1:0] l);
        logic [AW-1:0] r;
        r = {<<{x}};
        return r >> (SW'(AW) - l);
    endfunction

    // Smallest j >= from with bitrev(j) > j, so non-swapping indices cost no cycles.
    function automatic logic [AW:0] next_swap(input logic [AW-1:0] from, input logic [AW-1:0] n,
                                              input logic [SW-1:0] l);
        logic [AW:0]   res;
        logic [AW-1:0] jv;
        res = '0;
        for (int j = 2047; j >= 0; j--) begin
            jv = AW'(j);
            if (jv >= from && jv < n && bit_rev(jv, l) > jv) res = {1'b1, jv};
        end
        return res;
    endfunction
`endif

    function automatic logic [SW-1:0] log2_of(input logic [AW-1:0] n);
        logic [SW-1:0] l;
        l = '0;
        for (int b = 0; b < int'(AW); b++) if (n[b]) l = SW'(b);
        return l;
    endfunction

    assign l_in = log2_of(i_SAMPLES_NUMBER);
    assign n_ok = ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - 12'd1)) == 12'd0)
               && (i_SAMPLES_NUMBER >= 12'd2) && (i_SAMPLES_NUMBER <= 12'd2048);

    // Next-state, counters, and next-cycle output decode.
    always_comb begin
        state_nxt = state;
        n_nxt     = n_q;
        l_nxt     = l_q;
        s_nxt     = s_q;
        k_nxt     = k_q;
        w_nxt     = w_q;
`ifdef FFT_CALC_CTRL_BITREV_EN
        i_nxt     = i_q;
        swap_res  = '0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (i_DATA_LOADED) begin
                    n_nxt = i_SAMPLES_NUMBER;
                    l_nxt = l_in;
                    s_nxt = '0;
                    k_nxt = '0;
                    w_nxt = '0;
                    if (!n_ok) begin
                        state_nxt = S_DONE;
                    end else begin
`ifdef FFT_CALC_CTRL_BITREV_EN
                        swap_res  = next_swap(12'd0, i_SAMPLES_NUMBER, l_in);
                        i_nxt     = swap_res[AW-1:0];
                        state_nxt = swap_res[AW] ? S_BR_A : S_RD_A;
`else
                        state_nxt = S_RD_A;
`endif
                    end
                end
            end
            S_RD_A: state_nxt = S_RD_B;
            S_RD_B: begin
                state_nxt = S_WAIT;
                w_nxt     = '0;
            end
            S_WAIT: begin
                if (w_q == SW'(BFLY_LATENCY - 1)) state_nxt = S_WR_A;
                else w_nxt = w_q + 4'd1;
            end
            S_WR_A: state_nxt = S_WR_B;
            S_WR_B: begin
                state_nxt = S_RD_A;
                if (AW'(k_q) == (n_q >> 1) - 12'd1) begin
                    k_nxt = '0;
                    if (s_q == l_q - 4'd1) state_nxt = S_DONE;
                    else s_nxt = s_q + 4'd1;
                end else begin
                    k_nxt = k_q + 11'd1;
                end
            end
`ifdef FFT_CALC_CTRL_BITREV_EN
            S_BR_A: state_nxt = S_BR_B;
            S_BR_B: state_nxt = S_BW_A;
            S_BW_A: state_nxt = S_BW_B;
            S_BW_B: begin
                swap_res  = next_swap(i_q + 12'd1, n_q, l_q);
                i_nxt     = swap_res[AW-1:0];
                state_nxt = swap_res[AW] ? S_BR_A : S_RD_A;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        half_c = AW'(1) << s_nxt;
        pos_c  = AW'(k_nxt) & (half_c - 12'd1);
        top_c  = ((AW'(k_nxt) >> s_nxt) << (s_nxt + 4'd1)) + pos_c;
        bot_c  = top_c + half_c;
        tw_c   = KW'(pos_c << (l_nxt - 4'd1 - s_nxt));
`ifdef FFT_CALC_CTRL_BITREV_EN
        rev_c  = bit_rev(i_nxt, l_nxt);
`endif

        busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        end_nxt    = (state_nxt == S_DONE);
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        swap_nxt   = 1'b0;
        rd_idx_nxt = '0;
        wr_idx_nxt = '0;
        tw_nxt     = '0;
        stage_nxt  = '0;
        case (state_nxt)
            S_RD_A: begin rd_nxt = 1'b1; rd_idx_nxt = top_c; end
            S_RD_B: begin rd_nxt = 1'b1; rd_idx_nxt = bot_c; end
            S_WR_A: begin wr_nxt = 1'b1; wr_idx_nxt = top_c; end
            S_WR_B: begin wr_nxt = 1'b1; wr_idx_nxt = bot_c; end
`ifdef FFT_CALC_CTRL_BITREV_EN
            S_BR_A: begin rd_nxt = 1'b1; rd_idx_nxt = i_nxt; end
            S_BR_B: begin rd_nxt = 1'b1; rd_idx_nxt = rev_c; end
            S_BW_A: begin wr_nxt = 1'b1; wr_idx_nxt = i_nxt; swap_nxt = 1'b1; end
            S_BW_B: begin wr_nxt = 1'b1; wr_idx_nxt = rev_c; swap_nxt = 1'b1; end
`endif
            default: ;
        endcase
        if (state_nxt inside {S_RD_A, S_RD_B, S_WAIT, S_WR_A, S_WR_B}) begin
            tw_nxt    = tw_c;
            stage_nxt = s_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state           <= S_IDLE;
            n_q             <= '0;
            l_q             <= '0;
            s_q             <= '0;
            k_q             <= '0;
            w_q             <= '0;
`ifdef FFT_CALC_CTRL_BITREV_EN
            i_q             <= '0;
`endif
            o_CALC_END      <= 1'b0;
            o_BUSY          <= 1'b0;
            o_RD_ram        <= 1'b0;
            o_RD_INDEX_ram  <= '0;
            o_WR_ram        <= 1'b0;
            o_WR_INDEX_ram  <= '0;
            o_TWIDDLE_INDEX <= '0;
            o_STAGE         <= '0;
            o_SWAP          <= 1'b0;
        end else begin
            state           <= state_nxt;
            n_q             <= n_nxt;
            l_q             <= l_nxt;
            s_q             <= s_nxt;
            k_q             <= k_nxt;
            w_q             <= w_nxt;
`ifdef FFT_CALC_CTRL_BITREV_EN
            i_q             <= i_nxt;
`endif
            o_CALC_END      <= end_nxt;
            o_BUSY          <= busy_nxt;
            o_RD_ram        <= rd_nxt;
            o_RD_INDEX_ram  <= rd_idx_nxt;
            o_WR_ram        <= wr_nxt;
            o_WR_INDEX_ram  <= wr_idx_nxt;
            o_TWIDDLE_INDEX <= tw_nxt;
            o_STAGE         <= stage_nxt;
            o_SWAP          <= swap_nxt;
        end
    end
endmodule

// File: tb/tb_fft_calc_ctrl.sv
// tb_fft_calc_ctrl: randomized cycle-accurate checks of fft_calc_ctrl against a loop-based schedule model.
module tb_fft_calc_ctrl;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        loaded = 1'b0;
    logic [11:0] nsamp = '0;
    logic        calc_end, busy, rd, wr, swap;
    logic [11:0] rd_idx, wr_idx;
    logic [10:0] tw;
    logic [3:0]  stage;

    int tests = 0;
    int fails = 0;
    int swap_cycles = 0;
    logic [43:0] expq[$];
    logic [43:0] dutq[$];

    always #5 clk = ~clk;

    fft_calc_ctrl #(.BFLY_LATENCY(LAT)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_DATA_LOADED(loaded), .i_SAMPLES_NUMBER(nsamp),
        .o_CALC_END(calc_end), .o_BUSY(busy), .o_RD_ram(rd), .o_RD_INDEX_ram(rd_idx),
        .o_WR_ram(wr), .o_WR_INDEX_ram(wr_idx), .o_TWIDDLE_INDEX(tw), .o_STAGE(stage),
        .o_SWAP(swap)
    );

    // Layout: [43]busy [42]end [41]rd [40:29]rd_idx [28]wr [27:16]wr_idx [15:5]tw [4:1]stage [0]swap
    function automatic logic [43:0] rec(input bit b, input bit e, input bit r, input int ri,
                                        input bit w, input int wi, input int t, input int s,
                                        input bit sw);
        return {b, e, r, 12'(ri), w, 12'(wi), 11'(t), 4'(s), sw};
    endfunction

    function automatic logic [43:0] dut_vec();
        return {busy, calc_end, rd, rd_idx, wr, wr_idx, tw, stage, swap};
    endfunction

    function automatic int ilog2(input int n);
        int l = 0;
        while ((1 << l) < n) l++;
        return l;
    endfunction

    function automatic int brev(input int x, input int l);
        int r = 0;
        for (int b = 0; b < l; b++) if ((x >> b) & 1) r += 1 << (l - 1 - b);
        return r;
    endfunction

    // Expected per-cycle schedule from start acceptance through the first DONE cycle.
    function automatic void build(input int n);
        int L, half, pos, top, bot, t;
        expq.delete();
        L = ilog2(n);
        swap_cycles = 0;
`ifdef FFT_CALC_CTRL_BITREV_EN
        for (int i = 0; i < n; i++) begin
            int r = brev(i, L);
            if (r > i) begin
                expq.push_back(rec(1, 0, 1, i, 0, 0, 0, 0, 0));
                expq.push_back(rec(1, 0, 1, r, 0, 0, 0, 0, 0));
                expq.push_back(rec(1, 0, 0, 0, 1, i, 0, 0, 1));
                expq.push_back(rec(1, 0, 0, 0, 1, r, 0, 0, 1));
                swap_cycles += 4;
            end
        end
`endif
        for (int s = 0; s < L; s++) begin
            for (int k = 0; k < n / 2; k++) begin
                half = 2 ** s;
                pos  = k % half;
                top  = (k / half) * 2 * half + pos;
                bot  = top + half;
                t    = pos * (2 ** (L - 1 - s));
                expq.push_back(rec(1, 0, 1, top, 0, 0, t, s, 0));
                expq.push_back(rec(1, 0, 1, bot, 0, 0, t, s, 0));
                for (int w = 0; w < int'(LAT); w++) expq.push_back(rec(1, 0, 0, 0, 0, 0, t, s, 0));
                expq.push_back(rec(1, 0, 0, 0, 1, top, t, s, 0));
                expq.push_back(rec(1, 0, 0, 0, 1, bot, t, s, 0));
            end
        end
        expq.push_back(rec(0, 1, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    // Start a transform of size n and check every cycle; optional mid-run pulse / reset (relative to stage 0).
    task automatic run(input string name, input int n, input int pulse_at, input int abort_at);
        build(n);
        dutq.delete();
        @(negedge clk);
        nsamp  = 12'(n);
        loaded = 1'b1;
        for (int idx = 0; idx < expq.size(); idx++) begin
            @(negedge clk);
            if (abort_at >= 0 && idx == swap_cycles + abort_at) begin
                rstn = 1'b0;
                #1;
                tests++;
                if (dut_vec() !== 44'd0) begin
                    fails++;
                    $display("FAIL %s_reset_async got=%h exp=0", name, dut_vec());
                end
                loaded = 1'b0;
                return;
            end
            dutq.push_back(dut_vec());
            tests++;
            if (dut_vec() !== expq[idx]) begin
                fails++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, idx, dut_vec(), expq[idx]);
            end
            loaded = (idx == pulse_at);
            if (idx == pulse_at) nsamp = 12'($urandom_range(2, 4095));
        end
        loaded = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dut_vec() !== 44'd0) begin
            fails++;
            $display("FAIL reset_hold got=%h exp=0", dut_vec());
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (dut_vec() !== 44'd0) begin
            fails++;
            $display("FAIL reset_idle got=%h exp=0", dut_vec());
        end
    endtask

    task automatic test_invalid();
        int sizes[4];
        sizes[0] = 6; sizes[1] = 1; sizes[2] = 0; sizes[3] = 3000 + int'($urandom_range(1, 40));
        foreach (sizes[j]) begin
            @(negedge clk);
            nsamp  = 12'(sizes[j]);
            loaded = 1'b1;
            @(negedge clk);
            loaded = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tests++;
                if (dut_vec() !== rec(0, 1, 0, 0, 0, 0, 0, 0, 0)) begin
                    fails++;
                    $display("FAIL invalid_n%0d c=%0d got=%h exp=done_only", sizes[j], c, dut_vec());
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_n2();
        run("n2", 2, -1, -1);
    endtask

    task automatic test_n8();
        int nbusy = 0;
        int b;
        run("n8", 8, -1, -1);
        foreach (dutq[j]) if (dutq[j][43]) nbusy++;
        tests++;
        if (nbusy != 72 + swap_cycles) begin
            fails++;
            $display("FAIL n8_busy_cycles got=%0d exp=%0d", nbusy, 72 + swap_cycles);
        end
        b = swap_cycles + 5 * 6;
        tests++;
        if (dutq.size() <= b + 1 || dutq[b][40:29] !== 12'd1 || dutq[b + 1][40:29] !== 12'd3
            || dutq[b][15:5] !== 11'd2 || dutq[b][4:1] !== 4'd1) begin
            fails++;
            $display("FAIL n8_s1k1 got_top=%0d got_bot=%0d got_tw=%0d got_st=%0d exp=1/3/2/1",
                     dutq[b][40:29], dutq[b + 1][40:29], dutq[b][15:5], dutq[b][4:1]);
        end
    endtask

    task automatic test_swap();
        int nsw = 0;
        int exp_sw;
`ifdef FFT_CALC_CTRL_BITREV_EN
        exp_sw = 4;
`else
        exp_sw = 0;
`endif
        run("swap8", 8, -1, -1);
        foreach (dutq[j]) if (dutq[j][0]) nsw++;
        tests++;
        if (nsw != exp_sw) begin
            fails++;
            $display("FAIL swap_count got=%0d exp=%0d", nsw, exp_sw);
        end
    endtask

    task automatic test_restart_ignored();
        run("restart16", 16, 20 + int'($urandom_range(0, 40)), -1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== rec(0, 1, 0, 0, 0, 0, 0, 0, 0)) begin
                fails++;
                $display("FAIL calc_end_hold c=%0d got=%h exp=done_only", c, dut_vec());
            end
        end
        run("after_done", 4, -1, -1);
    endtask

    task automatic test_reset_mid();
        run("abort16", 16, -1, 8 * 6 + int'($urandom_range(0, 40)));
        @(negedge clk);
        tests++;
        if (dut_vec() !== 44'd0) begin
            fails++;
            $display("FAIL abort_in_reset got=%h exp=0", dut_vec());
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (dut_vec() !== 44'd0) begin
            fails++;
            $display("FAIL abort_no_calc_end got=%h exp=0", dut_vec());
        end
        run("fresh16", 16, -1, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) run("rand", 1 << $urandom_range(1, 6), -1, -1);
    endtask

    initial begin
        test_reset();
        test_invalid();
        test_n2();
        test_n8();
        test_swap();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
